// File: rtl/frog_mover.sv
// Player sprite grid mover: one button press becomes one animated row/column step,
// with a one-deep press buffer, platform drift, lives, score and game-over tracking.
module frog_mover #(
    parameter int H_WIDTH     = 11,
    parameter int H_HEIGHT    = 11,
    parameter int IX          = 320,
    parameter int ROW0_Y      = 24,
    parameter int ROW_PITCH   = 48,
    parameter int N_ROWS      = 10,
    parameter int X_STEP      = 20,
    parameter int X_MIN       = 20,
    parameter int X_MAX       = 620,
    parameter int SPEED       = 4,
    parameter int LIVES       = 3,
    parameter int RESPAWN_FR  = 30,
    parameter int BTN_ACT_LOW = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ani_stb,
    input  logic        i_animate,
    input  logic        i_up_btn,
    input  logic        i_down_btn,
    input  logic        i_left_btn,
    input  logic        i_right_btn,
    input  logic        i_dead,
    input  logic        i_drift_en,
    input  logic        i_drift_dir,
    output logic [11:0] o_x1,
    output logic [11:0] o_x2,
    output logic [11:0] o_y1,
    output logic [11:0] o_y2,
    output logic [3:0]  o_row,
    output logic        o_moving,
    output logic        o_win,
    output logic [3:0]  o_lives,
    output logic [7:0]  o_score,
    output logic        o_game_over
);

    localparam int          DW        = (RESPAWN_FR > 1) ? $clog2(RESPAWN_FR) : 1;
    localparam logic [3:0]  SPAWN_ROW = 4'(N_ROWS - 1);
    localparam logic [11:0] SPAWN_Y   = 12'(ROW0_Y + (N_ROWS - 1) * ROW_PITCH);
    localparam logic [3:0]  BTN_IDLE  = (BTN_ACT_LOW != 0) ? 4'b1111 : 4'b0000;
    localparam logic [1:0]  DIR_UP    = 2'd0;
    localparam logic [1:0]  DIR_DOWN  = 2'd1;
    localparam logic [1:0]  DIR_LEFT  = 2'd2;
    localparam logic [1:0]  DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {IDLE, MOVE, DYING, OVER} state_t;

    state_t          state;
    logic [3:0]      sync1;
    logic [3:0]      sync2;
    logic [3:0]      btn_prev;
    logic [3:0]      btn_act;
    logic [3:0]      rise;
    logic            fresh_vld;
    logic [1:0]      fresh_dir;
    logic            iss_vld;
    logic [1:0]      iss_dir;
    logic            cand_ok;
    logic [3:0]      cand_row;
    logic [11:0]     cand_x;
    logic [11:0]     x;
    logic [11:0]     y;
    logic [11:0]     tx;
    logic [11:0]     ty;
    logic [3:0]      row;
    logic [3:0]      lives;
    logic [7:0]      score;
    logic            buf_vld;
    logic [1:0]      buf_dir;
    logic            win;
    logic            moving;
    logic            game_over;
    logic [DW-1:0]   dcnt;
    logic            drift_stb;
    logic            drift_off;
    logic [11:0]     drift_x;
    logic            arrived;
    logic            die_now;

    function automatic logic [11:0] row_y(input logic [3:0] r);
        row_y = 12'(ROW0_Y) + 12'(ROW_PITCH) * {8'd0, r};
    endfunction

    // Move one coordinate toward its target by at most SPEED, never past it.
    function automatic logic [11:0] step_to(input logic [11:0] cur, input logic [11:0] tgt);
        logic [11:0] d;
        if (cur < tgt) begin
            d       = tgt - cur;
            step_to = cur + ((d > 12'(SPEED)) ? 12'(SPEED) : d);
        end else if (cur > tgt) begin
            d       = cur - tgt;
            step_to = cur - ((d > 12'(SPEED)) ? 12'(SPEED) : d);
        end else begin
            step_to = cur;
        end
    endfunction

    // Button synchroniser and rising-edge history, order {up, down, left, right}.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1    <= BTN_IDLE;
            sync2    <= BTN_IDLE;
            btn_prev <= 4'b0000;
        end else begin
            sync1    <= {i_up_btn, i_down_btn, i_left_btn, i_right_btn};
            sync2    <= sync1;
            btn_prev <= btn_act;
        end
    end

    assign btn_act   = (BTN_ACT_LOW != 0) ? ~sync2 : sync2;
    assign rise      = btn_act & ~btn_prev;
    assign ty        = row_y(row);
    assign arrived   = (x == tx) && (y == ty);
    assign drift_stb = i_ani_stb & i_animate & i_drift_en;
    assign drift_off = i_drift_dir ? (x >= 12'(X_MAX)) : (x <= 12'(X_MIN));
    assign drift_x   = i_drift_dir ? (x + 12'd1) : (x - 12'd1);
    assign iss_vld   = buf_vld | fresh_vld;
    assign iss_dir   = buf_vld ? buf_dir : fresh_dir;

    // Same-cycle presses resolve up > down > left > right.
    always_comb begin
        fresh_vld = |rise;
        if (rise[3]) begin
            fresh_dir = DIR_UP;
        end else if (rise[2]) begin
            fresh_dir = DIR_DOWN;
        end else if (rise[1]) begin
            fresh_dir = DIR_LEFT;
        end else begin
            fresh_dir = DIR_RIGHT;
        end
    end

    // Target of the press being issued, and whether it stays on the grid.
    always_comb begin
        cand_row = row;
        cand_x   = x;
        cand_ok  = 1'b0;
        case (iss_dir)
            DIR_UP: begin
                cand_ok  = (row != 4'd0);
                cand_row = row - 4'd1;
            end
            DIR_DOWN: begin
                cand_ok  = (row != SPAWN_ROW);
                cand_row = row + 4'd1;
            end
            DIR_LEFT: begin
                cand_ok = (x >= 12'(X_MIN + X_STEP));
                cand_x  = x - 12'(X_STEP);
            end
            DIR_RIGHT: begin
                cand_ok = (x <= 12'(X_MAX - X_STEP));
                cand_x  = x + 12'(X_STEP);
            end
            default: begin
                cand_ok = 1'b0;
            end
        endcase
    end

    // Death has priority over every other event, including a goal arrival.
    always_comb begin
        if (state == IDLE) begin
            die_now = i_dead | (drift_stb & drift_off);
        end else if (state == MOVE) begin
            die_now = i_dead;
        end else begin
            die_now = 1'b0;
        end
    end

    // Main sprite state machine.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            x         <= 12'(IX);
            tx        <= 12'(IX);
            y         <= SPAWN_Y;
            row       <= SPAWN_ROW;
            lives     <= 4'(LIVES);
            score     <= 8'd0;
            buf_vld   <= 1'b0;
            buf_dir   <= DIR_UP;
            win       <= 1'b0;
            moving    <= 1'b0;
            game_over <= 1'b0;
            dcnt      <= '0;
        end else begin
            win <= 1'b0;
            if (die_now) begin
                lives   <= lives - 4'd1;
                buf_vld <= 1'b0;
                moving  <= 1'b0;
                if (lives == 4'd1) begin
                    state     <= OVER;
                    game_over <= 1'b1;
                end else begin
                    state <= DYING;
                    dcnt  <= '0;
                    x     <= 12'(IX);
                    tx    <= 12'(IX);
                    y     <= SPAWN_Y;
                    row   <= SPAWN_ROW;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (iss_vld) begin
                            // A fresh press arriving while the buffer issues is kept for later.
                            buf_vld <= buf_vld & fresh_vld;
                            buf_dir <= fresh_dir;
                            if (cand_ok) begin
                                row    <= cand_row;
                                tx     <= cand_x;
                                state  <= MOVE;
                                moving <= 1'b1;
                            end
                        end else if (drift_stb) begin
                            x  <= drift_x;
                            tx <= drift_x;
                        end
                    end
                    MOVE: begin
                        if (arrived) begin
                            moving <= 1'b0;
                            state  <= IDLE;
                            if (row == 4'd0) begin
                                win     <= 1'b1;
                                score   <= (score != 8'd255) ? (score + 8'd1) : score;
                                buf_vld <= 1'b0;
                                x       <= 12'(IX);
                                tx      <= 12'(IX);
                                y       <= SPAWN_Y;
                                row     <= SPAWN_ROW;
                            end else if (fresh_vld) begin
                                buf_vld <= 1'b1;
                                buf_dir <= fresh_dir;
                            end
                        end else begin
                            if (i_ani_stb && i_animate) begin
                                x <= step_to(x, tx);
                                y <= step_to(y, ty);
                            end
                            if (fresh_vld) begin
                                buf_vld <= 1'b1;
                                buf_dir <= fresh_dir;
                            end
                        end
                    end
                    DYING: begin
                        if (i_ani_stb) begin
                            if (dcnt == DW'(RESPAWN_FR - 1)) begin
                                state <= IDLE;
                                dcnt  <= '0;
                            end else begin
                                dcnt <= dcnt + 1'b1;
                            end
                        end
                    end
                    OVER: begin
                        game_over <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Registered bounding box for the renderer and collision logic.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_x1 <= 12'(IX - H_WIDTH);
            o_x2 <= 12'(IX + H_WIDTH);
            o_y1 <= SPAWN_Y - 12'(H_HEIGHT);
            o_y2 <= SPAWN_Y + 12'(H_HEIGHT);
        end else begin
            o_x1 <= x - 12'(H_WIDTH);
            o_x2 <= x + 12'(H_WIDTH);
            o_y1 <= y - 12'(H_HEIGHT);
            o_y2 <= y + 12'(H_HEIGHT);
        end
    end

    assign o_row       = row;
    assign o_moving    = moving;
    assign o_win       = win;
    assign o_lives     = lives;
    assign o_score     = score;
    assign o_game_over = game_over;

endmodule

// File: tb/tb_frog_mover.sv
// Self-checking bench for frog_mover: press table with scoreboard plus hand-written
// sequences for stepping, holding, buffering, drift death, game-over and mid-move reset.
module tb_frog_mover;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_ani_stb = 1'b0;
    logic        i_animate = 1'b1;
    logic        i_up_btn = 1'b1;
    logic        i_down_btn = 1'b1;
    logic        i_left_btn = 1'b1;
    logic        i_right_btn = 1'b1;
    logic        i_dead = 1'b0;
    logic        i_drift_en = 1'b0;
    logic        i_drift_dir = 1'b0;
    logic [11:0] o_x1, o_x2, o_y1, o_y2;
    logic [3:0]  o_row;
    logic        o_moving, o_win, o_game_over;
    logic [3:0]  o_lives;
    logic [7:0]  o_score;

    int checks = 0;
    int errors = 0;
    int win_cnt = 0;

    typedef struct {
        logic [3:0]  btn;
        logic [3:0]  row;
        logic [11:0] x;
        logic [7:0]  score;
    } vec_t;

    typedef struct {
        string       name;
        logic [3:0]  row;
        logic [11:0] x;
        logic [11:0] y;
        logic [7:0]  score;
        logic [3:0]  lives;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   yq[$];

    frog_mover dut (
        .i_clk(clk), .i_rst(i_rst), .i_ani_stb(i_ani_stb), .i_animate(i_animate),
        .i_up_btn(i_up_btn), .i_down_btn(i_down_btn), .i_left_btn(i_left_btn),
        .i_right_btn(i_right_btn), .i_dead(i_dead), .i_drift_en(i_drift_en),
        .i_drift_dir(i_drift_dir), .o_x1(o_x1), .o_x2(o_x2), .o_y1(o_y1), .o_y2(o_y2),
        .o_row(o_row), .o_moving(o_moving), .o_win(o_win), .o_lives(o_lives),
        .o_score(o_score), .o_game_over(o_game_over)
    );

    initial forever #5 clk = ~clk;

    // One animation strobe every four clocks.
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            i_ani_stb = 1'b1;
            @(negedge clk);
            i_ani_stb = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (o_win === 1'b1) win_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [11:0] y_of(input int r);
        return 12'(24 + r * 48);
    endfunction

    task automatic set_btn(input logic [3:0] b);
        {i_up_btn, i_down_btn, i_left_btn, i_right_btn} = ~b;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_exp(input exp_t e);
        chk({e.name, "_x1"}, 32'(o_x1), 32'(e.x - 12'd11));
        chk({e.name, "_x2"}, 32'(o_x2), 32'(e.x + 12'd11));
        chk({e.name, "_y1"}, 32'(o_y1), 32'(e.y - 12'd11));
        chk({e.name, "_y2"}, 32'(o_y2), 32'(e.y + 12'd11));
        chk({e.name, "_row"}, 32'(o_row), 32'(e.row));
        chk({e.name, "_score"}, 32'(o_score), 32'(e.score));
        chk({e.name, "_lives"}, 32'(o_lives), 32'(e.lives));
    endtask

    // Press, release, then wait for the resulting move (if any) to finish.
    task automatic press_and_settle(input logic [3:0] b, input string nm);
        bit seen;
        bit done;
        seen = 1'b0;
        done = 1'b0;
        @(negedge clk);
        set_btn(b);
        for (int n = 0; n < 600 && !done; n++) begin
            @(negedge clk);
            if (n == 6) set_btn(4'b0000);
            if (o_moving) seen = 1'b1;
            if (n > 6 && ((seen && !o_moving) || (!seen && n >= 40))) done = 1'b1;
        end
        if (!done) chk({nm, "_timeout"}, 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        logic [11:0] prev_y;
        bit done;

        // Reset state
        do_reset();
        chk("rst_x1", 32'(o_x1), 32'd309);
        chk("rst_x2", 32'(o_x2), 32'd331);
        chk("rst_y1", 32'(o_y1), 32'd445);
        chk("rst_y2", 32'(o_y2), 32'd467);
        chk("rst_row", 32'(o_row), 32'd9);
        chk("rst_lives", 32'(o_lives), 32'd3);
        chk("rst_score", 32'(o_score), 32'd0);
        chk("rst_moving", 32'(o_moving), 32'd0);
        chk("rst_win", 32'(o_win), 32'd0);
        chk("rst_over", 32'(o_game_over), 32'd0);

        // First press up: y must pass 452,448,...,408 one strobe at a time
        for (int i = 0; i < 12; i++) yq.push_back(452 - 4 * i);
        prev_y = o_y1;
        done = 1'b0;
        set_btn(4'b1000);
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            if (n == 6) set_btn(4'b0000);
            if (o_y1 != prev_y) begin
                prev_y = o_y1;
                if (yq.size() == 0) chk("ystep_extra", 32'(o_y1) + 32'd11, 32'd0);
                else chk("ystep", 32'(o_y1) + 32'd11, 32'(yq.pop_front()));
            end
            if (n > 20 && !o_moving) done = 1'b1;
        end
        chk("ystep_left", 32'(yq.size()), 32'd0);
        chk("ystep_row", 32'(o_row), 32'd8);

        // Press table from a fresh reset: {buttons up/down/left/right, row, x, score}
        vecs.push_back('{4'b1000, 4'd8, 12'd320, 8'd0});
        vecs.push_back('{4'b0100, 4'd9, 12'd320, 8'd0});
        vecs.push_back('{4'b0100, 4'd9, 12'd320, 8'd0});
        vecs.push_back('{4'b0010, 4'd9, 12'd300, 8'd0});
        vecs.push_back('{4'b0001, 4'd9, 12'd320, 8'd0});
        vecs.push_back('{4'b1010, 4'd8, 12'd320, 8'd0});
        vecs.push_back('{4'b0110, 4'd9, 12'd320, 8'd0});
        for (int i = 1; i <= 8; i++) vecs.push_back('{4'b1000, 4'(9 - i), 12'd320, 8'd0});
        vecs.push_back('{4'b1000, 4'd9, 12'd320, 8'd1});
        for (int i = 1; i <= 15; i++) vecs.push_back('{4'b0001, 4'd9, 12'(320 + 20 * i), 8'd1});
        vecs.push_back('{4'b0001, 4'd9, 12'd620, 8'd1});
        vecs.push_back('{4'b0010, 4'd9, 12'd600, 8'd1});

        do_reset();
        win_cnt = 0;
        foreach (vecs[i]) begin
            e.name  = $sformatf("vec%0d", i);
            e.row   = vecs[i].row;
            e.x     = vecs[i].x;
            e.y     = y_of(int'(vecs[i].row));
            e.score = vecs[i].score;
            e.lives = 4'd3;
            sbq.push_back(e);
            press_and_settle(vecs[i].btn, e.name);
            check_exp(sbq.pop_front());
        end
        chk("win_once", 32'(win_cnt), 32'd1);

        // Drift right to 619, then off the right edge
        i_drift_dir = 1'b1;
        i_drift_en  = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            if (o_x1 == 12'd608) done = 1'b1;
        end
        i_drift_en = 1'b0;
        chk("drift_619", 32'(o_x1) + 32'd11, 32'd619);
        chk("drift_lives3", 32'(o_lives), 32'd3);
        i_drift_en = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (o_lives != 4'd3) done = 1'b1;
        end
        i_drift_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("drift_lives2", 32'(o_lives), 32'd2);
        chk("drift_respawn_x", 32'(o_x1) + 32'd11, 32'd320);
        chk("drift_respawn_y", 32'(o_y1) + 32'd11, 32'd456);

        // i_dead during the respawn freeze is ignored
        i_dead = 1'b1;
        @(negedge clk);
        i_dead = 1'b0;
        repeat (2) @(negedge clk);
        chk("dying_ignore_dead", 32'(o_lives), 32'd2);
        repeat (140) @(negedge clk);
        i_dead = 1'b1;
        @(negedge clk);
        i_dead = 1'b0;
        repeat (2) @(negedge clk);
        chk("dead_lives1", 32'(o_lives), 32'd1);
        chk("dead_not_over", 32'(o_game_over), 32'd0);
        repeat (140) @(negedge clk);
        i_dead = 1'b1;
        @(negedge clk);
        i_dead = 1'b0;
        repeat (2) @(negedge clk);
        chk("dead_lives0", 32'(o_lives), 32'd0);
        chk("game_over", 32'(o_game_over), 32'd1);
        press_and_settle(4'b1000, "over_press");
        chk("over_row", 32'(o_row), 32'd9);
        chk("over_y", 32'(o_y1) + 32'd11, 32'd456);
        chk("over_lives", 32'(o_lives), 32'd0);
        chk("over_score", 32'(o_score), 32'd1);
        chk("over_hold", 32'(o_game_over), 32'd1);

        // Holding up for 100 frames moves one row only
        do_reset();
        set_btn(4'b1000);
        repeat (400) @(negedge clk);
        set_btn(4'b0000);
        repeat (20) @(negedge clk);
        chk("hold_row", 32'(o_row), 32'd8);
        chk("hold_y", 32'(o_y1) + 32'd11, 32'd408);

        // Left pressed during an up move is issued after arrival
        do_reset();
        set_btn(4'b1000);
        repeat (6) @(negedge clk);
        set_btn(4'b0000);
        repeat (10) @(negedge clk);
        chk("buf_moving", 32'(o_moving), 32'd1);
        set_btn(4'b0010);
        repeat (6) @(negedge clk);
        set_btn(4'b0000);
        repeat (200) @(negedge clk);
        chk("buf_x", 32'(o_x1) + 32'd11, 32'd300);
        chk("buf_y", 32'(o_y1) + 32'd11, 32'd408);
        chk("buf_row", 32'(o_row), 32'd8);
        chk("buf_idle", 32'(o_moving), 32'd0);

        // Reset in the middle of a move takes effect at once
        do_reset();
        set_btn(4'b1000);
        repeat (20) @(negedge clk);
        set_btn(4'b0000);
        i_rst = 1'b1;
        #1;
        chk("midrst_y", 32'(o_y1) + 32'd11, 32'd456);
        chk("midrst_row", 32'(o_row), 32'd9);
        chk("midrst_moving", 32'(o_moving), 32'd0);
        chk("midrst_x", 32'(o_x1) + 32'd11, 32'd320);
        repeat (2) @(negedge clk);
        i_rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
